imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Hardware program loader for the pipelined RISC-V core's instruction memory. It accepts a stream of instruction words over a valid/ready interface and writes them through the IMEM write port (we0/wr_addr0/wr_din0) at a programmable base and byte stride. It can optionally read the words back to verify a checksum. It holds the core's PC in reset (resetpc low) until the image is loaded and verified, then releases it. It replaces bench-driven loops with one reusable block for both simulation and FPGA boot.

Parameters:
ADDR_W, 9, width of IMEM byte address (wr_addr0, rd_addr)
DATA_W, 32, instruction word width
MAX_WORDS, 128, maximum image length in words
STRIDE, 4, byte increment between consecutive words
RELEASE_DELAY, 2, cycles between verify pass and resetpc rising (>=1)
VERIFY_EN, 1, 1 = readback checksum pass after load; 0 = skip

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  begin load; sampled only in IDLE, RUN or ERROR
base_addr  in  ADDR_W  byte address of word 0; latched on start
word_count  in  clog2(MAX_WORDS+1)  words to load; latched on start
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_ready  out  1  loader accepts s_data this cycle
we0  out  1  IMEM write enable, one-cycle pulse per word
wr_addr0  out  ADDR_W  IMEM write byte address
wr_din0  out  DATA_W  IMEM write data
rd_addr  out  ADDR_W  IMEM readback address
rd_data  in  DATA_W  IMEM readback data, valid 1 cycle after rd_addr
resetpc  out  1  0 = core PC held in reset, 1 = core runs
busy  out  1  high in LOAD, VERIFY and HOLD
done  out  1  one-cycle pulse when resetpc rises
error  out  1  sticky high in ERROR
checksum  out  DATA_W  mod-2^DATA_W sum of accepted words

Behaviour:
- Clock is clk; reset is synchronous and active-high. On reset, all outputs are 0: we0, wr_addr0, wr_din0, rd_addr, s_ready, resetpc, busy, done, error, checksum. The internal index is 0 and the state is IDLE. Reset mid-load aborts immediately. Words already written stay in IMEM.
- States: IDLE, LOAD, VERIFY, HOLD, RUN, ERROR.
- IDLE/RUN/ERROR with start=1:
  - word_count > MAX_WORDS -> ERROR.
  - word_count == 0 -> HOLD, with no writes.
  - otherwise -> LOAD.
  - In every case: latch base_addr and word_count, clear idx, checksum and error, and drive resetpc=0 from the next cycle.
- start while busy is ignored.
- LOAD:
  - s_ready = (state==LOAD) && idx<count, decoded from registers.
  - Each handshake (s_valid & s_ready) registers we0=1, wr_addr0 = base + idx*STRIDE (truncated mod 2^ADDR_W, so addresses wrap silently) and wr_din0=s_data.
  - checksum += s_data; idx++.
  - Throughput is 1 word/clk. Write latency is 1 clk after the handshake.
  - we0=0 on non-handshake cycles; wr_addr0 and wr_din0 hold their last values.
  - After the last handshake: -> VERIFY if VERIFY_EN, else -> HOLD.
  - s_valid stalls of any length are tolerated. s_ready is 0 in every other state.
- VERIFY:
  - Emit rd_addr = base + j*STRIDE for j = 0..count-1, one per cycle, starting the cycle after the last we0.
  - Accumulate rd_data one cycle later into vsum.
  - After count+1 cycles: vsum == checksum -> HOLD; otherwise -> ERROR.
- HOLD: wait RELEASE_DELAY cycles with resetpc=0, then resetpc=1 and done=1 for one cycle -> RUN.
- RUN: resetpc stays 1; the loader is passive until start triggers a reload.
- ERROR: error=1 and resetpc=0, held until start or reset.
- checksum stays valid after RUN and after ERROR until the next start.

Test Plan:
- Baseline: base=0, count=77, 77 words streamed back-to-back. Expect:
  - 77 we0 pulses at addresses 0..304 step 4.
  - Verify passes; resetpc rises RELEASE_DELAY clk after VERIFY ends.
  - done pulses once; checksum equals the bench sum.
- Stalled stream: s_valid toggles 1,0,0,1, count=4, base=0x40, VERIFY_EN=0. Expect:
  - we0 only on the cycles after handshakes, at addresses 0x40, 0x44, 0x48, 0x4C.
  - resetpc=0 until 2 clk after the last write.
- Wrap and mismatch: base=0x1F8, count=4. Expect writes to 0x1F8, 0x1FC, 0x000, 0x004. Then the bench model corrupts the word at 0x000 on readback -> error=1, resetpc stays 0. A second start with clean memory -> RUN.
- Boundaries:
  - count=0 -> no we0; resetpc=1 after RELEASE_DELAY.
  - count=129 -> ERROR next cycle with no writes.
  - start during LOAD -> ignored.
- Reload and reset: in RUN, start again -> resetpc falls next clk and a full reload completes. Assert reset on the 10th word of a load -> all outputs 0 next clk, IDLE, s_ready=0.

Source files
------------

// File: rtl/imem_loader.sv
// Streams instruction words into IMEM at base + idx*STRIDE, optionally verifies a readback checksum, then releases the core PC.
// Latency: IMEM write 1 clk after each handshake; resetpc rises RELEASE_DELAY clk after LOAD (or VERIFY) completes.
// Backpressure: s_ready is high only in LOAD while words remain; s_valid stalls of any length are absorbed.
module imem_loader #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int MAX_WORDS     = 128,
    parameter int STRIDE        = 4,
    parameter int RELEASE_DELAY = 2,
    parameter bit VERIFY_EN     = 1'b1,
    localparam int CW           = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CW-1:0]     word_count,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [DATA_W-1:0] wr_din0,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              resetpc,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);
    // vcnt must reach count+1 (last readback sample), hence one extra bit
    localparam int VW = CW + 1;
    localparam int HW = $clog2(RELEASE_DELAY + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     idx_q;
    logic [VW-1:0]     vcnt_q;
    logic [DATA_W-1:0] vsum_q;
    logic [HW-1:0]     hold_cnt_q;

    logic              start_ok;
    logic              too_long;
    logic              hs;
    logic              last_word;
    logic              verify_last;
    logic              verify_ok;
    logic              hold_last;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;

    // start is only honoured when the loader is not busy
    assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERROR));
    assign too_long    = word_count > CW'(MAX_WORDS);

    // s_ready decodes registers only, so it never depends on s_valid
    assign s_ready     = (state_q == ST_LOAD) && (idx_q < count_q);
    assign hs          = s_valid && s_ready;
    assign last_word   = idx_q == (count_q - CW'(1));

    // Readback: rd_addr for word j is visible at vcnt=j+1, its data at vcnt=j+2,
    // so the final word's data is summed in the same cycle the comparison is made.
    assign verify_last = vcnt_q == (VW'(count_q) + VW'(1));
    assign verify_ok   = (vsum_q + rd_data) == checksum;
    assign hold_last   = hold_cnt_q == HW'(RELEASE_DELAY - 1);

    assign busy        = (state_q == ST_LOAD) || (state_q == ST_VERIFY) || (state_q == ST_HOLD);

    // Addresses wrap silently modulo 2^ADDR_W
    assign wr_addr_nxt = base_q + (ADDR_W'(idx_q) * ADDR_W'(STRIDE));
    assign rd_addr_nxt = base_q + (ADDR_W'(vcnt_q) * ADDR_W'(STRIDE));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    if (too_long) begin
                        state_d = ST_ERROR;
                    end else if (word_count == '0) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (hs && last_word) begin
                    state_d = VERIFY_EN ? ST_VERIFY : ST_HOLD;
                end
            end
            ST_VERIFY: begin
                if (verify_last) begin
                    state_d = verify_ok ? ST_HOLD : ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (hold_last) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs: write port, readback, checksum, release
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            vcnt_q     <= '0;
            vsum_q     <= '0;
            hold_cnt_q <= '0;
            we0        <= 1'b0;
            wr_addr0   <= '0;
            wr_din0    <= '0;
            rd_addr    <= '0;
            resetpc    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            checksum   <= '0;
        end else begin
            we0  <= 1'b0;
            done <= 1'b0;

            if (start_ok) begin
                base_q     <= base_addr;
                count_q    <= word_count;
                idx_q      <= '0;
                vcnt_q     <= '0;
                vsum_q     <= '0;
                hold_cnt_q <= '0;
                checksum   <= '0;
                resetpc    <= 1'b0;
                error      <= too_long;
            end

            if (hs) begin
                we0      <= 1'b1;
                wr_addr0 <= wr_addr_nxt;
                wr_din0  <= s_data;
                checksum <= checksum + s_data;
                idx_q    <= idx_q + CW'(1);
            end

            if (state_q == ST_VERIFY) begin
                vcnt_q <= vcnt_q + VW'(1);
                if (vcnt_q < VW'(count_q)) begin
                    rd_addr <= rd_addr_nxt;
                end
                if (vcnt_q >= VW'(2)) begin
                    vsum_q <= vsum_q + rd_data;
                end
                if (verify_last && !verify_ok) begin
                    error <= 1'b1;
                end
            end

            if (state_q == ST_HOLD) begin
                hold_cnt_q <= hold_cnt_q + HW'(1);
                if (hold_last) begin
                    resetpc <= 1'b1;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes and done/error events,
// negedge monitors pop and compare whenever the DUTs present them.
// Two instances: dut (readback verify on) and dut_nv (verify off).
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int RD     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              start_nv = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [7:0]        word_count = '0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;

    logic              s_ready, we0, resetpc, busy, done, error;
    logic [ADDR_W-1:0] wr_addr0, rd_addr;
    logic [DATA_W-1:0] wr_din0, checksum;
    logic [DATA_W-1:0] rd_data = '0;

    logic              s_ready_nv, we0_nv, resetpc_nv, busy_nv, done_nv, error_nv;
    logic [ADDR_W-1:0] wr_addr0_nv, rd_addr_nv;
    logic [DATA_W-1:0] wr_din0_nv, checksum_nv;
    logic [DATA_W-1:0] rd_data_nv = '0;

    imem_loader #(.VERIFY_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .we0(we0), .wr_addr0(wr_addr0),
        .wr_din0(wr_din0), .rd_addr(rd_addr), .rd_data(rd_data), .resetpc(resetpc), .busy(busy),
        .done(done), .error(error), .checksum(checksum)
    );

    imem_loader #(.VERIFY_EN(1'b0)) dut_nv (
        .clk(clk), .reset(reset), .start(start_nv), .base_addr(base_addr), .word_count(word_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_nv), .we0(we0_nv), .wr_addr0(wr_addr0_nv),
        .wr_din0(wr_din0_nv), .rd_addr(rd_addr_nv), .rd_data(rd_data_nv), .resetpc(resetpc_nv), .busy(busy_nv),
        .done(done_nv), .error(error_nv), .checksum(checksum_nv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    typedef struct {
        bit                is_err;
        logic [DATA_W-1:0] sum;
        int                cyc;
    } ev_t;

    wr_t wq[$];
    wr_t wq_nv[$];
    ev_t evq[$];
    ev_t evq_nv[$];

    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                last_cyc = 0;
    logic [DATA_W-1:0] exp_sum = '0;
    logic              corrupt = 1'b0;
    logic              err_d = 1'b0;
    logic              err_nv_d = 1'b0;
    logic [DATA_W-1:0] mem [0:127];

    always @(posedge clk) cyc <= cyc + 1;

    // IMEM model for the verifying instance; optional single-bit corruption of word 0 on readback
    always @(posedge clk) begin
        if (we0) mem[wr_addr0[8:2]] <= wr_din0;
        rd_data <= mem[rd_addr[8:2]] ^ ((corrupt && rd_addr == '0) ? 32'h1 : 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write and event monitors for the verifying instance
    always @(negedge clk) begin : mon
        wr_t w;
        ev_t e;
        if (we0) begin
            if (wq.size() == 0) begin
                chk("unexpected_we0", {23'd0, wr_addr0}, 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("wr_addr0", {23'd0, wr_addr0}, {23'd0, w.addr});
                chk("wr_din0", wr_din0, w.data);
                chk("wr_cycle", cyc, w.cyc);
            end
        end
        if (done || (error && !err_d)) begin
            if (evq.size() == 0) begin
                chk("unexpected_event", {30'd0, done, error}, 32'd0);
            end else begin
                e = evq.pop_front();
                chk("evt_is_error", {31'd0, error}, {31'd0, e.is_err});
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_checksum", checksum, e.sum);
                chk("evt_resetpc", {31'd0, resetpc}, {31'd0, !e.is_err});
            end
        end
        err_d = error;
    end

    // Write and event monitors for the non-verifying instance
    always @(negedge clk) begin : mon_nv
        wr_t w;
        ev_t e;
        if (we0_nv) begin
            if (wq_nv.size() == 0) begin
                chk("nv_unexpected_we0", {23'd0, wr_addr0_nv}, 32'hFFFF_FFFF);
            end else begin
                w = wq_nv.pop_front();
                chk("nv_wr_addr0", {23'd0, wr_addr0_nv}, {23'd0, w.addr});
                chk("nv_wr_din0", wr_din0_nv, w.data);
                chk("nv_wr_cycle", cyc, w.cyc);
            end
        end
        if (done_nv || (error_nv && !err_nv_d)) begin
            if (evq_nv.size() == 0) begin
                chk("nv_unexpected_event", {30'd0, done_nv, error_nv}, 32'd0);
            end else begin
                e = evq_nv.pop_front();
                chk("nv_evt_is_error", {31'd0, error_nv}, {31'd0, e.is_err});
                chk("nv_evt_cycle", cyc, e.cyc);
                chk("nv_evt_checksum", checksum_nv, e.sum);
                chk("nv_evt_resetpc", {31'd0, resetpc_nv}, {31'd0, !e.is_err});
            end
        end
        err_nv_d = error_nv;
    end

    task automatic do_start(input bit sel, input logic [ADDR_W-1:0] b, input logic [7:0] n);
        base_addr  = b;
        word_count = n;
        if (sel) start_nv = 1'b1;
        else     start    = 1'b1;
        tick();
        start    = 1'b0;
        start_nv = 1'b0;
    endtask

    task automatic push_ev(input bit sel, input bit is_err, input logic [DATA_W-1:0] sum, input int c);
        ev_t e;
        e.is_err = is_err;
        e.sum    = sum;
        e.cyc    = c;
        if (sel) evq_nv.push_back(e);
        else     evq.push_back(e);
    endtask

    // Presents n words with valid pattern vmask (cycled); optionally pulses start at word start_at
    // or asserts reset when word reset_at is presented. Expected writes are pushed on each handshake.
    task automatic stream(input bit sel, input int n, input logic [ADDR_W-1:0] base,
                          input logic [DATA_W-1:0] seed, input logic [3:0] vmask,
                          input int start_at, input int reset_at);
        int   i;
        int   ph;
        int   budget;
        bit   fired;
        bit   reset_hit;
        logic rdy;
        wr_t  w;
        i = 0; ph = 0; budget = 0; fired = 0; reset_hit = 0;
        exp_sum = '0;
        while (i < n && budget < 1000) begin
            budget++;
            s_valid = vmask[ph % 4];
            ph++;
            s_data = seed + (32'(i) * 32'h0101_0103);
            if (s_valid && i == reset_at) begin
                reset = 1'b1;
                tick();
                reset     = 1'b0;
                reset_hit = 1;
                break;
            end
            if (s_valid && i == start_at && !fired) begin
                fired      = 1;
                start      = 1'b1;
                base_addr  = 9'h100;
                word_count = 8'd3;
            end
            rdy = sel ? s_ready_nv : s_ready;
            if (s_valid && rdy) begin
                w.addr = base + ADDR_W'(i * 4);
                w.data = s_data;
                w.cyc  = cyc + 1;
                if (sel) wq_nv.push_back(w);
                else     wq.push_back(w);
                exp_sum  = exp_sum + s_data;
                last_cyc = cyc + 1;
                i++;
            end
            tick();
            start = 1'b0;
        end
        s_valid = 1'b0;
        chk("stream_words", i, (reset_hit ? reset_at : n));
    endtask

    task automatic wait_ev(input bit sel, input int budget);
        int k;
        k = 0;
        while (((sel ? evq_nv.size() : evq.size()) != 0) && k < budget) begin
            tick();
            k++;
        end
        chk("evt_wait", (sel ? evq_nv.size() : evq.size()), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we0"}, {31'd0, we0}, 0);
        chk({tag, "_wr_addr0"}, {23'd0, wr_addr0}, 0);
        chk({tag, "_wr_din0"}, wr_din0, 0);
        chk({tag, "_rd_addr"}, {23'd0, rd_addr}, 0);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 0);
        chk({tag, "_resetpc"}, {31'd0, resetpc}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_done"}, {31'd0, done}, 0);
        chk({tag, "_error"}, {31'd0, error}, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = '0;

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        chk("reset_nv_resetpc", {31'd0, resetpc_nv}, 0);
        chk("reset_nv_s_ready", {31'd0, s_ready_nv}, 0);
        reset = 1'b0;
        tick();

        // Baseline: 77 words at base 0, verify, release.
        // VERIFY lasts count+2 cycles after the last handshake edge, then HOLD lasts RD cycles.
        do_start(0, 9'h000, 8'd77);
        chk("base_busy", {31'd0, busy}, 1);
        stream(0, 77, 9'h000, 32'hA5A5_0000, 4'b1111, -1, -1);
        push_ev(0, 0, exp_sum, last_cyc + 77 + 2 + RD);
        chk("base_resetpc_low", {31'd0, resetpc}, 0);
        wait_ev(0, 300);
        tick();
        chk("base_run_resetpc", {31'd0, resetpc}, 1);
        chk("base_run_busy", {31'd0, busy}, 0);
        chk("base_checksum_kept", checksum, exp_sum);

        // Stalled stream on the non-verifying instance: valid pattern 1,0,0,1
        do_start(1, 9'h040, 8'd4);
        stream(1, 4, 9'h040, 32'hC0DE_0000, 4'b1001, -1, -1);
        push_ev(1, 0, exp_sum, last_cyc + RD);
        chk("stall_resetpc_t0", {31'd0, resetpc_nv}, 0);
        tick();
        chk("stall_resetpc_t1", {31'd0, resetpc_nv}, 0);
        wait_ev(1, 20);

        // Wrap with corrupted readback of word 0 -> ERROR one cycle after VERIFY ends
        corrupt = 1'b1;
        do_start(0, 9'h1F8, 8'd4);
        stream(0, 4, 9'h1F8, 32'h1234_0000, 4'b1111, -1, -1);
        push_ev(0, 1, exp_sum, last_cyc + 4 + 2);
        wait_ev(0, 50);
        repeat (3) tick();
        chk("wrap_error_held", {31'd0, error}, 1);
        chk("wrap_resetpc_low", {31'd0, resetpc}, 0);
        chk("wrap_checksum_kept", checksum, exp_sum);

        // Same image with clean memory -> RUN
        corrupt = 1'b0;
        do_start(0, 9'h1F8, 8'd4);
        chk("rerun_error_clear", {31'd0, error}, 0);
        stream(0, 4, 9'h1F8, 32'h1234_0000, 4'b1111, -1, -1);
        push_ev(0, 0, exp_sum, last_cyc + 4 + 2 + RD);
        wait_ev(0, 50);

        // count=0 from RUN: resetpc falls next clk, no writes, release after RD
        do_start(0, 9'h010, 8'd0);
        chk("zero_resetpc_fall", {31'd0, resetpc}, 0);
        chk("zero_busy", {31'd0, busy}, 1);
        push_ev(0, 0, 32'h0, cyc + RD);
        wait_ev(0, 20);

        // count=129 from RUN: ERROR on the next cycle, no writes
        do_start(0, 9'h000, 8'd129);
        push_ev(0, 1, 32'h0, cyc);
        wait_ev(0, 5);
        repeat (4) tick();
        chk("over_s_ready", {31'd0, s_ready}, 0);
        chk("over_resetpc", {31'd0, resetpc}, 0);
        chk("over_busy", {31'd0, busy}, 0);

        // Reload from ERROR with a start pulse mid-load, which must be ignored
        do_start(0, 9'h080, 8'd12);
        stream(0, 12, 9'h080, 32'h0BAD_F00D, 4'b1111, 3, -1);
        push_ev(0, 0, exp_sum, last_cyc + 12 + 2 + RD);
        wait_ev(0, 60);

        // Reload from RUN, reset asserted as the 10th word is presented
        do_start(0, 9'h000, 8'd20);
        chk("reload_resetpc_fall", {31'd0, resetpc}, 0);
        stream(0, 20, 9'h000, 32'h7777_0000, 4'b1111, -1, 9);
        chk_all_zero("midreset");
        tick();
        chk("midreset_s_ready_idle", {31'd0, s_ready}, 0);
        chk("midreset_busy_idle", {31'd0, busy}, 0);

        repeat (5) tick();
        chk("end_wq_empty", wq.size(), 0);
        chk("end_wq_nv_empty", wq_nv.size(), 0);
        chk("end_evq_empty", evq.size() + evq_nv.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
